// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester/mux bundle (req0/req1, D0/D1 in; gnt0/gnt1, S, Yb, busy out)
interface mux_rr_arbiter_if;
  logic req0;
  logic req1;
  logic D0;
  logic D1;
  logic gnt0;
  logic gnt1;
  logic S;
  logic Yb;
  logic busy;
  modport master (output req0, req1, D0, D1, input gnt0, gnt1, S, Yb, busy);
  modport slave (input req0, req1, D0, D1, output gnt0, gnt1, S, Yb, busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-way round-robin owner of a 2:1 inverting mux select (clk, reset, bus: req/D in, gnt/S/Yb/busy out)
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW = 4
) (
  input logic clk,
  input logic reset,
  mux_rr_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0 = 2'd1;
  localparam logic [1:0] G1 = 2'd2;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);
  logic [1:0] state, next;
  logic [CW-1:0] cnt;
  logic last, s_q, both;
  assign both = bus.req0 & bus.req1;
  always_comb begin
    next = state;
    if (state == IDLE)
      next = both ? (last ? G0 : G1) : bus.req0 ? G0 : bus.req1 ? G1 : IDLE;
    else if (state == G0)
      next = !bus.req0 ? (bus.req1 ? G1 : IDLE) : (bus.req1 && cnt == LIMIT) ? G1 : G0;
    else if (state == G1)
      next = !bus.req1 ? (bus.req0 ? G0 : IDLE) : (bus.req0 && cnt == LIMIT) ? G0 : G1;
    else
      next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s_q <= 1'b0;
      cnt <= '0;
      last <= 1'b1;
    end else begin
      state <= next;
      cnt <= (next != state || !both) ? '0 : cnt + 1'b1;
      if (next != state && next == G0) last <= 1'b0;
      if (next != state && next == G1) last <= 1'b1;
      s_q <= (next == G0) ? 1'b0 : (next == G1) ? 1'b1 : s_q;
    end
  end
  assign bus.gnt0 = (state == G0);
  assign bus.gnt1 = (state == G1);
  assign bus.busy = bus.gnt0 | bus.gnt1;
  assign bus.S = s_q;
  assign bus.Yb = ~(s_q ? bus.D1 : bus.D0);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed vectors feed a scoreboard queue; a monitor compares grants, select and Yb each cycle
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [8:0] vecs[$];
  logic [3:0] exp_q[$];
  bit done = 1'b0;
  mux_rr_arbiter_if bus();
  mux_rr_arbiter #(.MAX_HOLD(4), .CW(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic add(input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask
  initial begin
    // fields: reset req0 req1 D0 D1 | gnt0 gnt1 S Yb expected after the next edge
    add(9'b11100_0001, 2);
    add(9'b01110_1000, 4);
    add(9'b01110_0111, 4);
    add(9'b01110_1000, 4);
    add(9'b00110_0111, 1);
    add(9'b00111_0110, 1);
    add(9'b00101_0110, 1);
    add(9'b00110_0111, 1);
    add(9'b00000_0011, 1);
    add(9'b00001_0010, 1);
    add(9'b00101_0110, 1);
    add(9'b01101_0110, 2);
    add(9'b11101_0001, 1);
    add(9'b01101_1001, 1);
    add(9'b01001_1001, 4);
    add(9'b00011_0000, 1);
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.D0 = 1'b0;
    bus.D1 = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      {reset, bus.req0, bus.req1, bus.D0, bus.D1} = vecs[i][8:4];
      exp_q.push_back(vecs[i][3:0]);
    end
    repeat (3) @(negedge clk);
    done = 1'b1;
  end
  initial begin
    logic [3:0] e;
    @(posedge clk);
    while (!done) begin
      @(posedge clk);
      #1;
      if (bus.gnt0 && bus.gnt1) begin
        errors++;
        $display("FAIL overlap: gnt0=%b gnt1=%b, required not both high", bus.gnt0, bus.gnt1);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.S, bus.Yb} !== e) begin
          errors++;
          $display("FAIL outputs @%0t: gnt0,gnt1,S,Yb=%b required %b", $time, {bus.gnt0, bus.gnt1, bus.S, bus.Yb}, e);
        end
        checks++;
        if (bus.busy !== (e[3] | e[2])) begin
          errors++;
          $display("FAIL busy @%0t: got %b required %b", $time, bus.busy, e[3] | e[2]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #5000;
    $display("FAIL timeout: run did not complete within 5000 time units");
    $fatal(1);
  end
endmodule
